mod_cfg_sequencer: RTL and testbench
====================================

Name: mod_cfg_sequencer

Overview:
- Upstream control stage for mod_signal_gen; drives its FREQ_SEL, PHASE_SEL, DUTY_SEL and DRAIN_B inputs.
- Captures host (OK wire-in) settings and rejects illegal frequency codes.
- Applies every change as a drain → update → settle sequence so the imager never sees a half-applied configuration.
- Optional calibration sweep steps PHASE_SEL 0..31 with a programmable dwell per step.

Parameters:
- DRAIN_CYCLES, 16, cycles DRAIN_B is held low per apply (≥1).
- SETTLE_CYCLES, 1024, cycles waited after drain release before CFG_READY (≥1).
- DUTY_RST, 4'd8, DUTY_SEL value after reset (50%).

Ports:
- USER_CLOCK  in  1  system clock.
- RESET_B  in  1  reset, synchronous, active-low.
- HOST_FREQ_SEL  in  3  requested frequency code; 0..5 legal.
- HOST_PHASE_SEL  in  5  requested phase code.
- HOST_DUTY_SEL  in  4  requested duty code.
- HOST_APPLY  in  1  level from host; a rising edge requests an apply.
- SWEEP_EN  in  1  level; when high at apply, the apply runs a phase sweep.
- SWEEP_DWELL  in  16  cycles per sweep step; 0 is treated as 1.
- FREQ_SEL  out  3  registered, to mod_signal_gen.
- PHASE_SEL  out  5  registered, to mod_signal_gen.
- DUTY_SEL  out  4  registered, to mod_signal_gen.
- DRAIN_B  out  1  registered, active-low drain to imager / generator.
- CFG_READY  out  1  high only in IDLE.
- BUSY  out  1  equals ~CFG_READY.
- CFG_ERR  out  1  sticky; set on illegal-code apply.
- SWEEP_DONE  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Single clock. Clock is USER_CLOCK. Reset is RESET_B, synchronous, active-low. All outputs are registered.
- Reset values:
  - FREQ_SEL=0, PHASE_SEL=0, DUTY_SEL=DUTY_RST.
  - DRAIN_B=0, CFG_READY=0, BUSY=1, CFG_ERR=0, SWEEP_DONE=0.
  - pending=0, apply edge-detect register=0.
  - State=DRAIN with counter=0.
- The first cycle after reset release is DRAIN cycle 1. Power-up therefore runs a full drain + settle on the default configuration.
- Edge detect: an apply is HOST_APPLY=1 this cycle with the registered previous value 0. An apply seen outside IDLE sets pending=1. Further applies outside IDLE are absorbed; pending never exceeds one.
- States:
  - IDLE:
    - Outputs: CFG_READY=1, DRAIN_B=1.
    - Trigger: apply edge, or pending=1. Clear pending on acceptance.
    - Legality check: if HOST_FREQ_SEL>5, set CFG_ERR=1 and stay in IDLE; outputs unchanged.
    - Otherwise clear CFG_ERR and latch sweep_mode=SWEEP_EN.
    - Next cycle: FREQ_SEL/DUTY_SEL ← host values. PHASE_SEL ← 0 if sweep_mode, else HOST_PHASE_SEL. DRAIN_B=0. Go to DRAIN.
    - Host inputs are sampled in the trigger cycle only.
  - DRAIN:
    - DRAIN_B=0 for exactly DRAIN_CYCLES cycles, then go to SETTLE.
  - SETTLE:
    - DRAIN_B=1 for exactly SETTLE_CYCLES cycles.
    - Then go to DWELL if sweep_mode, else to IDLE.
  - DWELL:
    - DRAIN_B=1. Count max(SWEEP_DWELL,1) cycles; SWEEP_DWELL is sampled on entry to each step.
    - End of dwell with PHASE_SEL<31: PHASE_SEL+1 (no drain), restart dwell.
    - End of dwell with PHASE_SEL=31: SWEEP_DONE=1 for one cycle, go to IDLE, PHASE_SEL stays 31.
    - SWEEP_EN=0 sampled in DWELL: abort to IDLE next cycle. PHASE_SEL holds its current value; no SWEEP_DONE.
- Latency:
  - Apply edge at cycle t → outputs updated and DRAIN_B=0 at t+1.
  - DRAIN_B=1 at t+1+DRAIN_CYCLES.
  - CFG_READY=1 at t+1+DRAIN_CYCLES+SETTLE_CYCLES (non-sweep).
- Boundaries:
  - Counters are sized to the parameters; no wrap.
  - A PHASE_SEL increment happens only below 31 (no wrap to 0).
  - A pending apply is serviced on the first IDLE cycle. CFG_READY pulses high for that one cycle, then drops.
  - Reset asserted in any state overrides everything, including pending and sweep.
- Outputs change only on state entry or sweep step; never glitch mid-state.

Test Plan (DRAIN_CYCLES=4, SETTLE_CYCLES=8):
- Reset release → DRAIN_B low cycles 1–4, high from cycle 5. CFG_READY=1 at cycle 13. Outputs 0/0/8.
- From IDLE, HOST = freq 3 / phase 10 / duty 5, HOST_APPLY 0→1 at t:
  - FREQ_SEL=3, PHASE_SEL=10, DUTY_SEL=5 and DRAIN_B=0 at t+1.
  - DRAIN_B=1 at t+5; CFG_READY=1 at t+13.
- HOST_FREQ_SEL=6 with apply → CFG_ERR=1, no drain, outputs unchanged. A following legal apply clears CFG_ERR.
- SWEEP_EN=1, SWEEP_DWELL=2, apply at t:
  - PHASE_SEL=0 through settle, then steps 0→31 every 2 cycles.
  - SWEEP_DONE pulse once at t+13+64; PHASE_SEL ends at 31.
- Sweep running, SWEEP_EN dropped at PHASE_SEL=7 → IDLE next cycle, PHASE_SEL=7, no SWEEP_DONE.
- Two apply edges during SETTLE → exactly one additional drain sequence starts at the first IDLE cycle. Reset mid-DRAIN → reset values, pending cleared.

Source files
------------

// File: rtl/mod_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// mod_cfg_sequencer
//
// Upstream control stage for mod_signal_gen. Captures host configuration
// requests and applies each one as a drain -> update -> settle sequence. This
// ensures the imager never observes a half-applied configuration. Illegal
// frequency codes are rejected with a sticky error flag. An optional
// calibration sweep steps PHASE_SEL from 0 to 31 with a programmable dwell.
//
// Ports:
//   USER_CLOCK      in   1   system clock
//   RESET_B         in   1   synchronous active-low reset
//   HOST_FREQ_SEL   in   3   requested frequency code (0..5 legal)
//   HOST_PHASE_SEL  in   5   requested phase code
//   HOST_DUTY_SEL   in   4   requested duty code
//   HOST_APPLY      in   1   level; rising edge requests an apply
//   SWEEP_EN        in   1   level; high at apply selects a phase sweep
//   SWEEP_DWELL     in  16   cycles per sweep step (0 behaves as 1)
//   FREQ_SEL        out  3   registered frequency select
//   PHASE_SEL       out  5   registered phase select
//   DUTY_SEL        out  4   registered duty select
//   DRAIN_B         out  1   registered active-low drain
//   CFG_READY       out  1   high only while idle
//   BUSY            out  1   inverse of CFG_READY
//   CFG_ERR         out  1   sticky illegal-code flag
//   SWEEP_DONE      out  1   one-cycle pulse at sweep completion
// ----------------------------------------------------------------------------
module mod_cfg_sequencer #(
    parameter int unsigned DRAIN_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter logic [3:0]  DUTY_RST      = 4'd8
) (
    input  logic        USER_CLOCK,
    input  logic        RESET_B,
    input  logic [2:0]  HOST_FREQ_SEL,
    input  logic [4:0]  HOST_PHASE_SEL,
    input  logic [3:0]  HOST_DUTY_SEL,
    input  logic        HOST_APPLY,
    input  logic        SWEEP_EN,
    input  logic [15:0] SWEEP_DWELL,
    output logic [2:0]  FREQ_SEL,
    output logic [4:0]  PHASE_SEL,
    output logic [3:0]  DUTY_SEL,
    output logic        DRAIN_B,
    output logic        CFG_READY,
    output logic        BUSY,
    output logic        CFG_ERR,
    output logic        SWEEP_DONE
);

    // One shared counter serves drain, settle and dwell, so it must hold the
    // largest terminal count of the three.
    localparam int unsigned DR_W  = (DRAIN_CYCLES  > 1) ? $clog2(DRAIN_CYCLES)  : 1;
    localparam int unsigned ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned DS_W  = (DR_W > ST_W) ? DR_W : ST_W;
    localparam int unsigned CNT_W = (DS_W > 16) ? DS_W : 16;

    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       FREQ_MAX    = 3'd5;
    localparam logic [4:0]       PHASE_MAX   = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_SETTLE,
        S_DWELL
    } state_e;

    // Terminal count for one dwell step; a dwell of 0 behaves as 1 cycle.
    function automatic logic [15:0] dwell_last(input logic [15:0] dwell);
        return (dwell == 16'd0) ? 16'd0 : (dwell - 16'd1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      dwell_last_q, dwell_last_d;
    logic [2:0]       freq_q, freq_d;
    logic [4:0]       phase_q, phase_d;
    logic [3:0]       duty_q, duty_d;
    logic             drain_b_q, drain_b_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             pending_q, pending_d;
    logic             sweep_q, sweep_d;
    logic             apply_prev_q;
    logic             apply_edge;

    assign apply_edge = HOST_APPLY & ~apply_prev_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        dwell_last_d = dwell_last_q;
        freq_d       = freq_q;
        phase_d      = phase_q;
        duty_d       = duty_q;
        drain_b_d    = drain_b_q;
        err_d        = err_q;
        done_d       = 1'b0;
        pending_d    = pending_q;
        sweep_d      = sweep_q;

        // Requests arriving while busy collapse into a single pending flag.
        if ((state_q != S_IDLE) && apply_edge) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                drain_b_d = 1'b1;
                if (apply_edge || pending_q) begin
                    pending_d = 1'b0;
                    if (HOST_FREQ_SEL > FREQ_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        err_d     = 1'b0;
                        sweep_d   = SWEEP_EN;
                        freq_d    = HOST_FREQ_SEL;
                        duty_d    = HOST_DUTY_SEL;
                        phase_d   = SWEEP_EN ? 5'd0 : HOST_PHASE_SEL;
                        drain_b_d = 1'b0;
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_b_d = 1'b0;
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d     = '0;
                    drain_b_d = 1'b1;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                drain_b_d = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (sweep_q) begin
                        dwell_last_d = dwell_last(SWEEP_DWELL);
                        state_d      = S_DWELL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DWELL: begin
                drain_b_d = 1'b1;
                // Abort wins over a step boundary in the same cycle.
                if (!SWEEP_EN) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(dwell_last_q)) begin
                    cnt_d = '0;
                    if (phase_q == PHASE_MAX) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        phase_d      = phase_q + 5'd1;
                        dwell_last_d = dwell_last(SWEEP_DWELL);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge USER_CLOCK) begin
        if (!RESET_B) begin
            state_q      <= S_DRAIN;
            cnt_q        <= '0;
            freq_q       <= 3'd0;
            phase_q      <= 5'd0;
            duty_q       <= DUTY_RST;
            drain_b_q    <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            pending_q    <= 1'b0;
            sweep_q      <= 1'b0;
            apply_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            freq_q       <= freq_d;
            phase_q      <= phase_d;
            duty_q       <= duty_d;
            drain_b_q    <= drain_b_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            sweep_q      <= sweep_d;
            apply_prev_q <= HOST_APPLY;
        end
    end

    // Dwell length is always loaded before it is used, so it needs no reset.
    always_ff @(posedge USER_CLOCK) begin
        dwell_last_q <= dwell_last_d;
    end

    assign FREQ_SEL   = freq_q;
    assign PHASE_SEL  = phase_q;
    assign DUTY_SEL   = duty_q;
    assign DRAIN_B    = drain_b_q;
    assign CFG_READY  = ready_q;
    assign BUSY       = ~ready_q;
    assign CFG_ERR    = err_q;
    assign SWEEP_DONE = done_q;

endmodule

// File: tb/tb_mod_cfg_sequencer.sv
module tb_mod_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [2:0]  host_freq;
    logic [4:0]  host_phase;
    logic [3:0]  host_duty;
    logic        host_apply;
    logic        sweep_en;
    logic [15:0] sweep_dwell;
    logic [2:0]  freq_sel;
    logic [4:0]  phase_sel;
    logic [3:0]  duty_sel;
    logic        drain_b;
    logic        cfg_ready;
    logic        busy;
    logic        cfg_err;
    logic        sweep_done;

    always #5 clk = ~clk;

    mod_cfg_sequencer #(
        .DRAIN_CYCLES  (4),
        .SETTLE_CYCLES (8),
        .DUTY_RST      (4'd8)
    ) dut (
        .USER_CLOCK     (clk),
        .RESET_B        (rst_b),
        .HOST_FREQ_SEL  (host_freq),
        .HOST_PHASE_SEL (host_phase),
        .HOST_DUTY_SEL  (host_duty),
        .HOST_APPLY     (host_apply),
        .SWEEP_EN       (sweep_en),
        .SWEEP_DWELL    (sweep_dwell),
        .FREQ_SEL       (freq_sel),
        .PHASE_SEL      (phase_sel),
        .DUTY_SEL       (duty_sel),
        .DRAIN_B        (drain_b),
        .CFG_READY      (cfg_ready),
        .BUSY           (busy),
        .CFG_ERR        (cfg_err),
        .SWEEP_DONE     (sweep_done)
    );

    typedef enum int {SIG_FREQ, SIG_PHASE, SIG_DUTY, SIG_DRAIN, SIG_READY,
                      SIG_BUSY, SIG_ERR, SIG_DONE} sig_e;

    typedef struct {
        int    at;
        sig_e  sig;
        int    val;
        string nm;
    } exp_t;

    typedef struct {
        int freq;
        int phase;
        int duty;
        int e_freq;
        int e_phase;
        int e_duty;
        int e_err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int get_sig(sig_e s);
        case (s)
            SIG_FREQ:  return int'(freq_sel);
            SIG_PHASE: return int'(phase_sel);
            SIG_DUTY:  return int'(duty_sel);
            SIG_DRAIN: return int'(drain_b);
            SIG_READY: return int'(cfg_ready);
            SIG_BUSY:  return int'(busy);
            SIG_ERR:   return int'(cfg_err);
            default:   return int'(sweep_done);
        endcase
    endfunction

    task automatic check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Queue an expectation, keeping the scoreboard ordered by cycle.
    function automatic void expect_at(int at, sig_e s, int v, string nm);
        exp_t e;
        int   idx;
        bool_search: begin
            idx = sb.size();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at > at) idx = i;
            end
        end
        e = '{at: at, sig: s, val: v, nm: nm};
        sb.insert(idx, e);
    endfunction

    // Advance one clock; sample 1 time unit after the edge and retire due entries.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: sample missed, due cycle %0d, now %0d", e.nm, e.at, cyc);
            end else begin
                check(e.nm, get_sig(e.sig), e.val);
            end
        end
    endtask

    task automatic tick_until(int target);
        while (cyc < target) tick();
    endtask

    task automatic drain_sb(int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_freq"},  int'(freq_sel),   0);
        check({tag, "_phase"}, int'(phase_sel),  0);
        check({tag, "_duty"},  int'(duty_sel),   8);
        check({tag, "_drain"}, int'(drain_b),    0);
        check({tag, "_ready"}, int'(cfg_ready),  0);
        check({tag, "_busy"},  int'(busy),       1);
        check({tag, "_err"},   int'(cfg_err),    0);
        check({tag, "_done"},  int'(sweep_done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;

        vecs[0] = '{3, 10,  5, 3, 10,  5, 0};
        vecs[1] = '{6,  1,  1, 3, 10,  5, 1};
        vecs[2] = '{0, 31, 15, 0, 31, 15, 0};
        vecs[3] = '{7,  2,  2, 0, 31, 15, 1};
        vecs[4] = '{5,  0,  0, 5,  0,  0, 0};
        vecs[5] = '{2, 17,  9, 2, 17,  9, 0};

        rst_b       = 1'b0;
        host_freq   = 3'd0;
        host_phase  = 5'd0;
        host_duty   = 4'd0;
        host_apply  = 1'b0;
        sweep_en    = 1'b0;
        sweep_dwell = 16'd2;
        repeat (3) tick();

        // Power-up: DRAIN cycle 1 is the current cycle.
        rst_b = 1'b1;
        r = cyc;
        check_reset_values("reset");
        expect_at(r + 3,  SIG_DRAIN, 0, "pwr_drain_c4");
        expect_at(r + 4,  SIG_DRAIN, 1, "pwr_drain_c5");
        expect_at(r + 11, SIG_READY, 0, "pwr_ready_c12");
        expect_at(r + 12, SIG_READY, 1, "pwr_ready_c13");
        expect_at(r + 12, SIG_BUSY,  0, "pwr_busy_c13");
        expect_at(r + 12, SIG_DUTY,  8, "pwr_duty_c13");
        drain_sb(40);

        // Table-driven applies from IDLE.
        for (int i = 0; i < 6; i++) begin
            host_freq  = 3'(vecs[i].freq);
            host_phase = 5'(vecs[i].phase);
            host_duty  = 4'(vecs[i].duty);
            t = cyc;
            host_apply = 1'b1;
            expect_at(t + 1, SIG_FREQ,  vecs[i].e_freq,  $sformatf("v%0d_freq", i));
            expect_at(t + 1, SIG_PHASE, vecs[i].e_phase, $sformatf("v%0d_phase", i));
            expect_at(t + 1, SIG_DUTY,  vecs[i].e_duty,  $sformatf("v%0d_duty", i));
            expect_at(t + 1, SIG_ERR,   vecs[i].e_err,   $sformatf("v%0d_err", i));
            if (vecs[i].e_err == 0) begin
                expect_at(t + 1,  SIG_DRAIN, 0, $sformatf("v%0d_drain_t1", i));
                expect_at(t + 1,  SIG_BUSY,  1, $sformatf("v%0d_busy_t1", i));
                expect_at(t + 4,  SIG_DRAIN, 0, $sformatf("v%0d_drain_t4", i));
                expect_at(t + 5,  SIG_DRAIN, 1, $sformatf("v%0d_drain_t5", i));
                expect_at(t + 12, SIG_READY, 0, $sformatf("v%0d_ready_t12", i));
                expect_at(t + 13, SIG_READY, 1, $sformatf("v%0d_ready_t13", i));
            end else begin
                expect_at(t + 1, SIG_DRAIN, 1, $sformatf("v%0d_nodrain_t1", i));
                expect_at(t + 1, SIG_READY, 1, $sformatf("v%0d_ready_t1", i));
                expect_at(t + 2, SIG_DRAIN, 1, $sformatf("v%0d_nodrain_t2", i));
                expect_at(t + 2, SIG_ERR,   1, $sformatf("v%0d_err_t2", i));
            end
            tick();
            host_apply = 1'b0;
            drain_sb(40);
        end

        // Full phase sweep, dwell 2.
        host_freq   = 3'd1;
        host_phase  = 5'd20;
        host_duty   = 4'd3;
        sweep_en    = 1'b1;
        sweep_dwell = 16'd2;
        t = cyc;
        host_apply = 1'b1;
        expect_at(t + 1,  SIG_PHASE, 0,  "sw_phase_t1");
        expect_at(t + 1,  SIG_FREQ,  1,  "sw_freq_t1");
        expect_at(t + 1,  SIG_DUTY,  3,  "sw_duty_t1");
        expect_at(t + 12, SIG_PHASE, 0,  "sw_phase_settle");
        expect_at(t + 12, SIG_READY, 0,  "sw_ready_settle");
        expect_at(t + 13, SIG_PHASE, 0,  "sw_phase_step0a");
        expect_at(t + 14, SIG_PHASE, 0,  "sw_phase_step0b");
        expect_at(t + 15, SIG_PHASE, 1,  "sw_phase_step1");
        expect_at(t + 17, SIG_PHASE, 2,  "sw_phase_step2");
        expect_at(t + 45, SIG_PHASE, 16, "sw_phase_step16");
        expect_at(t + 73, SIG_PHASE, 30, "sw_phase_step30");
        expect_at(t + 75, SIG_PHASE, 31, "sw_phase_step31");
        expect_at(t + 76, SIG_DONE,  0,  "sw_done_early");
        expect_at(t + 76, SIG_READY, 0,  "sw_ready_early");
        expect_at(t + 77, SIG_DONE,  1,  "sw_done_pulse");
        expect_at(t + 77, SIG_READY, 1,  "sw_ready_end");
        expect_at(t + 77, SIG_PHASE, 31, "sw_phase_end");
        expect_at(t + 78, SIG_DONE,  0,  "sw_done_clear");
        expect_at(t + 78, SIG_PHASE, 31, "sw_phase_hold");
        tick();
        host_apply = 1'b0;
        drain_sb(200);

        // Sweep with SWEEP_DWELL=0 behaves as one cycle per step.
        host_freq   = 3'd4;
        host_phase  = 5'd9;
        host_duty   = 4'd6;
        sweep_dwell = 16'd0;
        t = cyc;
        host_apply = 1'b1;
        expect_at(t + 1,  SIG_FREQ,  4,  "sw0_freq_t1");
        expect_at(t + 1,  SIG_PHASE, 0,  "sw0_phase_t1");
        expect_at(t + 13, SIG_PHASE, 0,  "sw0_phase_0");
        expect_at(t + 14, SIG_PHASE, 1,  "sw0_phase_1");
        expect_at(t + 20, SIG_PHASE, 7,  "sw0_phase_7");
        expect_at(t + 44, SIG_PHASE, 31, "sw0_phase_31");
        expect_at(t + 44, SIG_DONE,  0,  "sw0_done_early");
        expect_at(t + 45, SIG_DONE,  1,  "sw0_done_pulse");
        expect_at(t + 45, SIG_READY, 1,  "sw0_ready_end");
        expect_at(t + 46, SIG_DONE,  0,  "sw0_done_clear");
        tick();
        host_apply = 1'b0;
        drain_sb(100);

        // Sweep aborted at PHASE_SEL=7.
        host_freq   = 3'd2;
        host_phase  = 5'd3;
        host_duty   = 4'd4;
        sweep_dwell = 16'd2;
        t = cyc;
        host_apply = 1'b1;
        expect_at(t + 25, SIG_PHASE, 6, "ab_phase_6");
        expect_at(t + 27, SIG_PHASE, 7, "ab_phase_7");
        expect_at(t + 27, SIG_READY, 0, "ab_ready_before");
        expect_at(t + 28, SIG_READY, 1, "ab_ready_idle");
        expect_at(t + 28, SIG_PHASE, 7, "ab_phase_idle");
        expect_at(t + 28, SIG_DONE,  0, "ab_done_none0");
        expect_at(t + 29, SIG_DONE,  0, "ab_done_none1");
        expect_at(t + 30, SIG_PHASE, 7, "ab_phase_hold");
        expect_at(t + 30, SIG_DRAIN, 1, "ab_drain_idle");
        tick();
        host_apply = 1'b0;
        tick_until(t + 27);
        sweep_en = 1'b0;
        drain_sb(50);

        // Two apply edges during SETTLE yield exactly one extra drain.
        host_freq  = 3'd1;
        host_phase = 5'd5;
        host_duty  = 4'd2;
        t = cyc;
        host_apply = 1'b1;
        expect_at(t + 1,  SIG_FREQ,  1, "pd_freq_a");
        expect_at(t + 13, SIG_READY, 1, "pd_ready_pulse");
        expect_at(t + 13, SIG_FREQ,  1, "pd_freq_hold");
        expect_at(t + 14, SIG_READY, 0, "pd_ready_drop");
        expect_at(t + 14, SIG_DRAIN, 0, "pd_drain_start");
        expect_at(t + 14, SIG_FREQ,  4, "pd_freq_b");
        expect_at(t + 14, SIG_PHASE, 12, "pd_phase_b");
        expect_at(t + 14, SIG_DUTY,  11, "pd_duty_b");
        expect_at(t + 17, SIG_DRAIN, 0, "pd_drain_last");
        expect_at(t + 18, SIG_DRAIN, 1, "pd_drain_release");
        expect_at(t + 26, SIG_READY, 1, "pd_ready_end");
        expect_at(t + 27, SIG_READY, 1, "pd_no_third");
        expect_at(t + 28, SIG_DRAIN, 1, "pd_no_third_drain");
        tick();
        host_apply = 1'b0;
        tick_until(t + 6);
        host_apply = 1'b1;
        tick();
        host_apply = 1'b0;
        tick();
        host_apply = 1'b1;
        tick();
        host_apply = 1'b0;
        host_freq  = 3'd4;
        host_phase = 5'd12;
        host_duty  = 4'd11;
        drain_sb(50);

        // Reset mid-DRAIN with an apply pending.
        host_freq  = 3'd3;
        host_phase = 5'd1;
        host_duty  = 4'd1;
        t = cyc;
        host_apply = 1'b1;
        expect_at(t + 1, SIG_DRAIN, 0, "rd_drain_t1");
        expect_at(t + 1, SIG_FREQ,  3, "rd_freq_t1");
        tick();
        host_apply = 1'b0;
        tick();
        host_apply = 1'b1;
        tick();
        rst_b = 1'b0;
        tick();
        rst_b      = 1'b1;
        host_apply = 1'b0;
        r = cyc;
        check_reset_values("rd_reset");
        expect_at(r + 11, SIG_READY, 0, "rd_ready_c12");
        expect_at(r + 12, SIG_READY, 1, "rd_ready_c13");
        expect_at(r + 13, SIG_READY, 1, "rd_no_pending");
        expect_at(r + 13, SIG_DRAIN, 1, "rd_no_pending_drain");
        expect_at(r + 13, SIG_FREQ,  0, "rd_freq_default");
        expect_at(r + 14, SIG_READY, 1, "rd_still_idle");
        drain_sb(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
